// File: rtl/muldiv_sequencer_if.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer_if
//   Request/response bundle between the core and the iterative M-extension
//   sequencer. The core drives the master side; the sequencer is the slave.
//
//   req_valid   core -> seq   request present
//   req_ready   seq  -> core  sequencer can accept a request
//   req_funct3  core -> seq   M-extension funct3 (MUL..REMU)
//   req_a       core -> seq   rs1 operand
//   req_b       core -> seq   rs2 operand
//   kill        core -> seq   abort any in-flight operation
//   resp_valid  seq  -> core  result available
//   resp_ready  core -> seq   core takes the result
//   resp_result seq  -> core  result value
//   busy        seq  -> core  sequencer not idle
// -----------------------------------------------------------------------------
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            kill;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_result;
    logic            busy;

    modport master (
        output req_valid, req_funct3, req_a, req_b, kill, resp_ready,
        input  req_ready, resp_valid, resp_result, busy
    );

    modport slave (
        input  req_valid, req_funct3, req_a, req_b, kill, resp_ready,
        output req_ready, resp_valid, resp_result, busy
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//   Iterative RV32M multiply/divide unit. One request per operation; a
//   radix-2 shift-add multiplier or restoring divider runs for XLEN cycles,
//   then a single fix-up cycle applies signs and selects the result.
//
//   Ports:
//     clock  in   core clock, rising edge
//     reset  in   asynchronous active-low reset
//     bus    slave modport of muldiv_sequencer_if (request/response handshake,
//            kill, busy)
//
//   Flow: IDLE -> CALC (XLEN cycles) -> FIX -> DONE -> IDLE.
//   Divide-by-zero and signed overflow skip CALC/FIX and go straight to DONE.
//   resp_valid is registered from the DONE state, so it rises one edge after
//   DONE is entered.
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic                clock,
    input  logic                reset,
    muldiv_sequencer_if.slave   bus
);
    localparam int                CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(XLEN - 1);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    // -------------------------------------------------------------------------
    // Sign helpers
    // -------------------------------------------------------------------------
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                  input logic            is_signed);
        return (is_signed && v[XLEN-1]) ? -v : v;
    endfunction

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                                 input logic            neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v,
                                                        input logic              neg);
        return neg ? -v : v;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t            state_q;
    // Multiply: {product_hi, multiplier/product_lo}. Divide: {remainder, quotient}.
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opb_q;      // multiplicand or divisor magnitude
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        funct3_q;
    logic              neg_q;      // product / quotient must be negated
    logic              rem_neg_q;  // remainder takes the sign of a
    logic              req_ready_q;
    logic              resp_valid_q;
    logic              busy_q;
    logic [XLEN-1:0]   result_q;

    // -------------------------------------------------------------------------
    // Request decode (only meaningful when a request fires)
    // -------------------------------------------------------------------------
    logic            fire_req;
    logic            is_div;
    logic            is_rem;
    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_result;

    assign fire_req = bus.req_valid && req_ready_q;
    assign is_div   = bus.req_funct3[2];
    assign is_rem   = bus.req_funct3[1];

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (bus.req_funct3)
            F_MUL, F_MULH, F_DIV, F_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            F_MULHSU: begin
                a_signed = 1'b1;
                b_signed = 1'b0;
            end
            default: begin
                a_signed = 1'b0;
                b_signed = 1'b0;
            end
        endcase
    end

    assign a_neg = a_signed && bus.req_a[XLEN-1];
    assign b_neg = b_signed && bus.req_b[XLEN-1];
    assign a_mag = magnitude(bus.req_a, a_signed);
    assign b_mag = magnitude(bus.req_b, b_signed);

    assign div_zero = is_div && (bus.req_b == '0);
    // Only the signed divide ops (funct3[0]==0) can overflow: -2^(XLEN-1) / -1.
    assign div_ovf  = is_div && !bus.req_funct3[0]
                      && (bus.req_a == {1'b1, {(XLEN-1){1'b0}}})
                      && (bus.req_b == '1);

    always_comb begin
        special_result = '0;
        if (div_zero) begin
            special_result = is_rem ? bus.req_a : '1;
        end else begin
            special_result = is_rem ? '0 : bus.req_a;
        end
    end

    // -------------------------------------------------------------------------
    // One iteration of the multiply / divide loop
    // -------------------------------------------------------------------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_trial;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] acc_d;

    // The XLEN+1-bit sum keeps the carry, which becomes the new top bit after
    // the right shift.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]}
                               : {1'b0, acc_q[2*XLEN-1:1]};

    // Remainder shifted left with the next dividend bit; bit XLEN of the
    // difference is set exactly when the trial value is below the divisor.
    assign div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff  = div_trial - {1'b0, opb_q};
    assign div_next  = !div_diff[XLEN]
                       ? {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1}
                       : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

    assign acc_d = funct3_q[2] ? div_next : mul_next;

    // -------------------------------------------------------------------------
    // Sign fix-up and result selection
    // -------------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   fix_d;

    assign prod_signed = cond_neg_wide(acc_q, neg_q);

    always_comb begin
        fix_d = '0;
        case (funct3_q)
            F_MUL:                      fix_d = prod_signed[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU:  fix_d = prod_signed[2*XLEN-1:XLEN];
            F_DIV, F_DIVU:              fix_d = cond_neg(acc_q[XLEN-1:0], neg_q);
            F_REM, F_REMU:              fix_d = cond_neg(acc_q[2*XLEN-1:XLEN], rem_neg_q);
            default:                    fix_d = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            opb_q        <= '0;
            cnt_q        <= '0;
            funct3_q     <= '0;
            neg_q        <= 1'b0;
            rem_neg_q    <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            result_q     <= '0;
        end else if (bus.kill) begin
            // Kill wins over both handshakes; any pending response is dropped.
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (fire_req) begin
                        funct3_q    <= bus.req_funct3;
                        neg_q       <= a_neg ^ b_neg;
                        rem_neg_q   <= a_neg;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (div_zero || div_ovf) begin
                            result_q <= special_result;
                            state_q  <= S_DONE;
                        end else begin
                            // Divide loads the dividend; multiply loads the
                            // multiplier into the low half.
                            acc_q   <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                            opb_q   <= is_div ? b_mag : a_mag;
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_q <= fix_d;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    if (!resp_valid_q) begin
                        resp_valid_q <= 1'b1;
                    end else if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_result = result_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
    localparam int XLEN = 32;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    muldiv_sequencer_if #(.XLEN(XLEN)) bus();

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Waits for req_ready, presents one request and returns right after the fire edge.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int g;
        g = 0;
        @(negedge clk);
        while (!bus.req_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        bus.req_valid  = 1'b1;
        bus.req_funct3 = f;
        bus.req_a      = a;
        bus.req_b      = b;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        // Operands must have been captured at fire; scramble them afterwards.
        bus.req_a      = $urandom;
        bus.req_b      = $urandom;
        bus.req_funct3 = 3'($urandom_range(0, 7));
    endtask

    // Counts edges after the fire edge until resp_valid is seen high.
    task automatic wait_resp(output int lat);
        lat = 0;
        while (!bus.resp_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_resp();
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        issue(f, a, b);
        wait_resp(lat);
        res = bus.resp_result;
        release_resp();
    endtask

    vec_t vecs[20];

    initial begin
        logic [31:0] res;
        int          lat;
        int          seen;

        vecs[0]  = '{"mul_7_m3",        F_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
        vecs[1]  = '{"mulh_min_min",    F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
        vecs[2]  = '{"mulhu_ones",      F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
        vecs[3]  = '{"mulhsu_m1_ones",  F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
        vecs[4]  = '{"div_m7_2",        F_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34};
        vecs[5]  = '{"rem_m7_2",        F_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34};
        vecs[6]  = '{"divu_by0",        F_DIVU,   32'd100,       32'd0,         32'hFFFF_FFFF, 1};
        vecs[7]  = '{"remu_by0",        F_REMU,   32'd100,       32'd0,         32'd100,       1};
        vecs[8]  = '{"div_ovf",         F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[9]  = '{"rem_ovf",         F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
        vecs[10] = '{"mul_shift",       F_MUL,    32'h1234_5678, 32'h10,        32'h2345_6780, 34};
        vecs[11] = '{"divu_100_7",      F_DIVU,   32'd100,       32'd7,         32'd14,        34};
        vecs[12] = '{"remu_100_7",      F_REMU,   32'd100,       32'd7,         32'd2,         34};
        vecs[13] = '{"div_by0_signed",  F_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[14] = '{"rem_by0_signed",  F_REM,    32'd5,         32'd0,         32'd5,         1};
        vecs[15] = '{"mulh_m1_m1",      F_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         34};
        vecs[16] = '{"mulhu_min_2",     F_MULHU,  32'h8000_0000, 32'd2,         32'd1,         34};
        vecs[17] = '{"div_7_m2",        F_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
        vecs[18] = '{"rem_7_m2",        F_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         34};
        vecs[19] = '{"mulh_m3_5",       F_MULH,   32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 34};

        passed = 0;
        total  = 0;
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.kill       = 1'b0;
        bus.resp_ready = 1'b0;

        // Reset state
        #12;
        check("rst_req_ready",  32'(bus.req_ready),  32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_result",     bus.resp_result,     32'd0);
        check("rst_busy",       32'(bus.busy),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table
        foreach (vecs[i]) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat);
            check({vecs[i].name, "_result"},  res,        vecs[i].exp);
            check({vecs[i].name, "_latency"}, 32'(lat),   32'(vecs[i].lat));
        end

        // Response held off for 5 cycles in DONE
        issue(F_MUL, 32'd3, 32'd5);
        check("hold_busy_after_fire", 32'(bus.busy), 32'd1);
        wait_resp(lat);
        check("hold_latency", 32'(lat), 32'd34);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_result_%0d", k),     bus.resp_result,     32'd15);
            check($sformatf("hold_req_ready_%0d", k),  32'(bus.req_ready),  32'd0);
            check($sformatf("hold_resp_valid_%0d", k), 32'(bus.resp_valid), 32'd1);
        end
        release_resp();
        check("release_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("release_req_ready",  32'(bus.req_ready),  32'd1);
        check("release_busy",       32'(bus.busy),       32'd0);
        // New request presented in the very next cycle must be accepted.
        bus.req_valid  = 1'b1;
        bus.req_funct3 = F_DIVU;
        bus.req_a      = 32'd1000;
        bus.req_b      = 32'd3;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("next_accept_busy", 32'(bus.busy), 32'd1);
        wait_resp(lat);
        check("next_result",  bus.resp_result, 32'd333);
        check("next_latency", 32'(lat),        32'd34);
        release_resp();

        // kill during CALC at counter 10
        issue(F_MUL, 32'd9, 32'd9);
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        check("kill_busy",       32'(bus.busy),       32'd0);
        check("kill_req_ready",  32'(bus.req_ready),  32'd1);
        check("kill_resp_valid", 32'(bus.resp_valid), 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid) seen++;
        end
        check("kill_no_resp", 32'(seen), 32'd0);
        run_op(F_MUL, 32'd9, 32'd9, res, lat);
        check("after_kill_result",  res,      32'd81);
        check("after_kill_latency", 32'(lat), 32'd34);

        // kill in DONE drops the pending response
        issue(F_DIVU, 32'd10, 32'd0);
        wait_resp(lat);
        check("kill_done_valid_before", 32'(bus.resp_valid), 32'd1);
        @(negedge clk);
        bus.kill       = 1'b1;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.kill       = 1'b0;
        bus.resp_ready = 1'b0;
        check("kill_done_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("kill_done_req_ready",  32'(bus.req_ready),  32'd1);

        // A request presented together with kill is not accepted
        @(negedge clk);
        bus.kill       = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_funct3 = F_MUL;
        bus.req_a      = 32'd2;
        bus.req_b      = 32'd2;
        @(posedge clk);
        #1;
        bus.kill      = 1'b0;
        bus.req_valid = 1'b0;
        check("kill_req_busy",      32'(bus.busy),      32'd0);
        check("kill_req_req_ready", 32'(bus.req_ready), 32'd1);

        // Asynchronous reset mid-CALC
        issue(F_DIVU, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_req_ready",  32'(bus.req_ready),  32'd1);
        check("async_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("async_rst_result",     bus.resp_result,     32'd0);
        check("async_rst_busy",       32'(bus.busy),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(F_REM, 32'hFFFF_FF9C, 32'd7, res, lat);
        check("after_rst_result",  res,      32'hFFFF_FFFE);
        check("after_rst_latency", 32'(lat), 32'd34);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
